// File: rtl/demux9to1v_stream.sv
// Registered 1-to-9 stream demultiplexer: each accepted word lands in a one-entry
// register for its channel; select codes 9-15 are accepted, discarded and counted.
module demux9to1v_stream #(
   parameter int unsigned WIDTH  = 16,
   parameter int unsigned DROP_W = 8
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WIDTH-1:0]  din,
   input  logic [3:0]        sel,
   output logic [8:0]        out_valid,
   input  logic [8:0]        out_ready,
   output logic [WIDTH-1:0]  a,
   output logic [WIDTH-1:0]  b,
   output logic [WIDTH-1:0]  c,
   output logic [WIDTH-1:0]  d,
   output logic [WIDTH-1:0]  e,
   output logic [WIDTH-1:0]  f,
   output logic [WIDTH-1:0]  g,
   output logic [WIDTH-1:0]  h,
   output logic [WIDTH-1:0]  i,
   output logic [DROP_W-1:0] drop_cnt,
   output logic              drop_seen
);

   localparam int unsigned NCH = 9;
   localparam int unsigned SW  = 4;

   logic [WIDTH-1:0] r [NCH];
   logic [NCH-1:0]   v;
   logic [15:0]      v_ext;
   logic [15:0]      rdy_ext;
   logic             sel_ok;
   logic             push;
   logic [WIDTH-1:0] dout [NCH];

   // Widen to 16 entries so every 4-bit select indexes in range.
   assign v_ext   = 16'(v);
   assign rdy_ext = 16'(out_ready);
   assign sel_ok  = (sel < SW'(NCH));

   // Drops never stall; a valid select waits only on its own channel.
   assign in_ready = sel_ok ? (!v_ext[sel] || rdy_ext[sel]) : 1'b1;
   assign push     = in_valid && in_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         v         <= '0;
         drop_cnt  <= '0;
         drop_seen <= 1'b0;
         for (int k = 0; k < NCH; k++) begin
            r[k] <= '1;
         end
      end else begin
         // A push to a channel wins over its pop, so the new word replaces the old.
         for (int k = 0; k < NCH; k++) begin
            if (push && sel_ok && (sel == SW'(k))) begin
               r[k] <= din;
               v[k] <= 1'b1;
            end else if (v[k] && out_ready[k]) begin
               v[k] <= 1'b0;
            end
         end
         if (push && !sel_ok) begin
            drop_seen <= 1'b1;
            if (drop_cnt != '1) begin
               drop_cnt <= drop_cnt + DROP_W'(1);
            end
         end
      end
   end

   // Empty channels present all-ones.
   for (genvar k = 0; k < NCH; k++) begin : g_out
      assign dout[k] = v[k] ? r[k] : '1;
   end

   assign out_valid = v;
   assign a = dout[0];
   assign b = dout[1];
   assign c = dout[2];
   assign d = dout[3];
   assign e = dout[4];
   assign f = dout[5];
   assign g = dout[6];
   assign h = dout[7];
   assign i = dout[8];

endmodule

// File: tb/tb_demux9to1v_stream.sv
// Bench for demux9to1v_stream: directed vector table, hand-written corner sequences
// and randomized traffic checked against a slot/counter reference model.
module tb_demux9to1v_stream;

   logic        clk;
   logic        resetn;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] din;
   logic [3:0]  sel;
   logic [8:0]  out_valid;
   logic [8:0]  out_ready;
   logic [15:0] a, b, c, d, e, f, g, h, i;
   logic [7:0]  drop_cnt;
   logic        drop_seen;
   logic [15:0] dch [9];

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: occupancy and word per slot, unsaturated drop total.
   bit          m_full [9];
   logic [15:0] m_word [9];
   int          m_drops;
   bit          m_seen;
   bit          model_ok = 0;

   demux9to1v_stream dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
      .din(din), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h), .i(i),
      .drop_cnt(drop_cnt), .drop_seen(drop_seen)
   );

   assign dch[0] = a; assign dch[1] = b; assign dch[2] = c;
   assign dch[3] = d; assign dch[4] = e; assign dch[5] = f;
   assign dch[6] = g; assign dch[7] = h; assign dch[8] = i;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic exp_ready(input logic [3:0] s, input logic [8:0] o);
      if (s >= 4'd9) return 1'b1;
      return !m_full[s] || o[s];
   endfunction

   task automatic model_step(input logic rn, input logic vl, input logic [3:0] s,
                             input logic [15:0] dd, input logic [8:0] o);
      logic acc;
      if (!rn) begin
         for (int k = 0; k < 9; k++) begin
            m_full[k] = 0;
            m_word[k] = 16'hFFFF;
         end
         m_drops = 0;
         m_seen  = 0;
         return;
      end
      acc = vl && exp_ready(s, o);
      for (int k = 0; k < 9; k++) begin
         if (m_full[k] && o[k]) m_full[k] = 0;
      end
      if (acc && s < 4'd9) begin
         m_full[s] = 1;
         m_word[s] = dd;
      end else if (acc) begin
         m_drops++;
         m_seen = 1;
      end
   endtask

   task automatic chk_model();
      logic [8:0] ov;
      for (int k = 0; k < 9; k++) begin
         ov[k] = m_full[k];
         chk($sformatf("m_ch%0d", k), 32'(dch[k]), 32'(m_full[k] ? m_word[k] : 16'hFFFF));
      end
      chk("m_out_valid", 32'(out_valid), 32'(ov));
      chk("m_drop_cnt", 32'(drop_cnt), 32'((m_drops > 255) ? 255 : m_drops));
      chk("m_drop_seen", 32'(drop_seen), 32'(m_seen));
   endtask

   // One clock: drive, check in_ready before the edge, then outputs after it.
   task automatic cycle(input logic rn, input logic vl, input logic [3:0] s,
                        input logic [15:0] dd, input logic [8:0] o, output logic rdy_s);
      resetn = rn; in_valid = vl; sel = s; din = dd; out_ready = o;
      #1;
      rdy_s = in_ready;
      if (model_ok) chk("m_in_ready", 32'(in_ready), 32'(exp_ready(s, o)));
      @(posedge clk);
      model_step(rn, vl, s, dd, o);
      model_ok = 1;
      #1;
      chk_model();
   endtask

   typedef struct {
      logic        rn;
      logic        vld;
      logic [3:0]  sel;
      logic [15:0] din;
      logic [8:0]  ordy;
      logic        rdy;
      logic [8:0]  ov;
      int          ch;
      logic [15:0] dat;
      logic [7:0]  cnt;
      logic        seen;
   } vec_t;

   vec_t tbl [11];

   initial begin
      logic r;
      resetn = 1'b0; in_valid = 1'b0; sel = 4'd0; din = 16'd0; out_ready = 9'd0;

      tbl[0]  = '{1'b0, 1'b1, 4'd3,  16'h1234, 9'h000, 1'b1, 9'h000, 3, 16'hFFFF, 8'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b1, 4'd3,  16'h1234, 9'h000, 1'b1, 9'h008, 3, 16'h1234, 8'd0, 1'b0};
      tbl[2]  = '{1'b1, 1'b1, 4'd3,  16'h5555, 9'h000, 1'b0, 9'h008, 3, 16'h1234, 8'd0, 1'b0};
      tbl[3]  = '{1'b1, 1'b1, 4'd3,  16'hBEEF, 9'h008, 1'b1, 9'h008, 3, 16'hBEEF, 8'd0, 1'b0};
      tbl[4]  = '{1'b1, 1'b1, 4'd8,  16'h00AA, 9'h000, 1'b1, 9'h108, 8, 16'h00AA, 8'd0, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 4'd8,  16'h0000, 9'h000, 1'b0, 9'h108, 3, 16'hBEEF, 8'd0, 1'b0};
      tbl[6]  = '{1'b1, 1'b1, 4'd12, 16'h0000, 9'h000, 1'b1, 9'h108, 0, 16'hFFFF, 8'd1, 1'b1};
      tbl[7]  = '{1'b1, 1'b0, 4'd0,  16'h0000, 9'h1FF, 1'b1, 9'h000, 3, 16'hFFFF, 8'd1, 1'b1};
      tbl[8]  = '{1'b1, 1'b1, 4'd5,  16'h1005, 9'h1FF, 1'b1, 9'h020, 5, 16'h1005, 8'd1, 1'b1};
      tbl[9]  = '{1'b1, 1'b1, 4'd5,  16'h2005, 9'h1FF, 1'b1, 9'h020, 5, 16'h2005, 8'd1, 1'b1};
      tbl[10] = '{1'b0, 1'b1, 4'd9,  16'h0000, 9'h000, 1'b1, 9'h000, 5, 16'hFFFF, 8'd0, 1'b0};

      // Bring the DUT out of an unknown state before any vector.
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 9'd0, r);

      foreach (tbl[n]) begin
         cycle(tbl[n].rn, tbl[n].vld, tbl[n].sel, tbl[n].din, tbl[n].ordy, r);
         chk($sformatf("tbl%0d_in_ready", n), 32'(r), 32'(tbl[n].rdy));
         chk($sformatf("tbl%0d_out_valid", n), 32'(out_valid), 32'(tbl[n].ov));
         chk($sformatf("tbl%0d_ch%0d", n, tbl[n].ch), 32'(dch[tbl[n].ch]), 32'(tbl[n].dat));
         chk($sformatf("tbl%0d_drop_cnt", n), 32'(drop_cnt), 32'(tbl[n].cnt));
         chk($sformatf("tbl%0d_drop_seen", n), 32'(drop_seen), 32'(tbl[n].seen));
      end

      // 300 drops: never stall, counter saturates at 255.
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 9'd0, r);
      for (int n = 0; n < 300; n++) begin
         cycle(1'b1, 1'b1, 4'd12, 16'($urandom), 9'd0, r);
         chk("drop_in_ready", 32'(r), 32'd1);
         if (n == 254) chk("drop_cnt_at_255", 32'(drop_cnt), 32'd255);
      end
      chk("drop_cnt_sat", 32'(drop_cnt), 32'd255);
      chk("drop_seen_set", 32'(drop_seen), 32'd1);
      chk("drop_out_valid", 32'(out_valid), 32'd0);

      // Back-to-back sel 0..8 with all consumers ready.
      cycle(1'b0, 1'b0, 4'd0, 16'd0, 9'd0, r);
      for (int k = 0; k < 9; k++) begin
         cycle(1'b1, 1'b1, 4'(k), 16'h1000 + 16'(k), 9'h1FF, r);
         chk($sformatf("b2b_valid%0d", k), 32'(out_valid), 32'(9'h001 << k));
         chk($sformatf("b2b_data%0d", k), 32'(dch[k]), 32'(16'h1000 + 16'(k)));
      end
      cycle(1'b1, 1'b0, 4'd0, 16'd0, 9'h1FF, r);
      chk("b2b_drained", 32'(out_valid), 32'd0);

      // Reset with four channels full and five drops recorded.
      for (int k = 0; k < 5; k++) cycle(1'b1, 1'b1, 4'(9 + k), 16'd0, 9'd0, r);
      for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 4'(k), 16'hA000 + 16'(k), 9'd0, r);
      chk("pre_rst_valid", 32'(out_valid), 32'h00F);
      chk("pre_rst_cnt", 32'(drop_cnt), 32'd5);
      cycle(1'b0, 1'b1, 4'd4, 16'h7777, 9'd0, r);
      chk("rst_valid", 32'(out_valid), 32'd0);
      for (int k = 0; k < 9; k++) chk($sformatf("rst_ch%0d", k), 32'(dch[k]), 32'hFFFF);
      chk("rst_cnt", 32'(drop_cnt), 32'd0);
      chk("rst_seen", 32'(drop_seen), 32'd0);

      // Randomized traffic against the model.
      for (int n = 0; n < 2000; n++) begin
         cycle(($urandom_range(0, 63) != 0), 1'($urandom), 4'($urandom_range(0, 15)),
               16'($urandom), 9'($urandom), r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
